demux_1to4_stream: RTL and testbench

//  Registered 1-to-4 stream demultiplexer: routes packets from one valid/ready input to one of

---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_1to4_stream_slot.sv | 37 +++
 rtl/demux_1to4_stream.sv | 130 +++++++++++++
 tb/tb_demux_1to4_stream.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer: lane geometry and FSM states.
package demux_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

endpackage : demux_pkg

// File: rtl/demux_1to4_stream_slot.sv
// One-entry output register slot with its own valid flag.
// A load always wins; a drain without a load empties the slot.
// The payload holds its last value while the slot is empty.
module stream_slot #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         ready,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_r;
  logic [W-1:0] q_r;

  // Slot occupancy and payload: reload on accept, empty on drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      q_r     <= '0;
    end else if (load) begin
      valid_r <= 1'b1;
      q_r     <= d;
    end else if (valid_r && ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid = valid_r;
  assign q     = q_r;

endmodule : stream_slot

// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream demultiplexer. The lane is taken from sel on a packet's
// first beat and held in route_r until the last beat; each lane has a one-entry slot
// and a wrapping count of completed packets.
module demux_1to4_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_last,
  input  logic [1:0]            sel,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  output logic [4*DATA_W-1:0]   out_data,
  output logic [3:0]            out_last,
  output logic [4*CNT_W-1:0]    pkt_cnt,
  output logic                  busy
);

  state_t                 state_r;
  logic [LANE_W-1:0]      route_r;
  logic                   busy_r;
  logic [LANE_W-1:0]      lane_s;
  logic                   accept_s;
  logic [NUM_LANES-1:0]   load_s;
  logic [NUM_LANES-1:0]   slot_valid_s;
  logic [CNT_W-1:0]       cnt_r [NUM_LANES];

  // Effective lane: sel only matters on a packet's first beat, then the held route applies.
  always_comb begin
    lane_s = route_r;
    if (state_r == IDLE) begin
      lane_s = sel;
    end else begin
      lane_s = route_r;
    end
  end

  // Ready mux: accept when the target slot is empty or draining this cycle; closed in reset.
  assign in_ready = rst_n & (~slot_valid_s[lane_s] | out_ready[lane_s]);
  assign accept_s = in_valid & in_ready;

  // Decode the accepted beat into a one-hot load for the target slot.
  always_comb begin
    load_s = {NUM_LANES{1'b0}};
    for (int i = 0; i < NUM_LANES; i++) begin
      if (accept_s && (lane_s == LANE_W'(i))) begin
        load_s[i] = 1'b1;
      end else begin
        load_s[i] = 1'b0;
      end
    end
  end

  // Packet FSM: lock the route on a non-final first beat, release it on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      route_r <= {LANE_W{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && !in_last) begin
            state_r <= IN_PKT;
            route_r <= sel;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        IN_PKT: begin
          if (accept_s && in_last) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= IN_PKT;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign out_valid = slot_valid_s;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [DATA_W:0] payload_s;

    stream_slot #(
      .W (DATA_W + 1)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_s[g]),
      .ready (out_ready[g]),
      .d     ({in_last, in_data}),
      .valid (slot_valid_s[g]),
      .q     (payload_s)
    );

    assign out_data[g*DATA_W +: DATA_W] = payload_s[DATA_W-1:0];
    assign out_last[g]                  = payload_s[DATA_W];

    // Completed-packet counter: bump when a last beat leaves the lane; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r[g] <= {CNT_W{1'b0}};
      end else if (slot_valid_s[g] && out_ready[g] && out_last[g]) begin
        cnt_r[g] <= cnt_r[g] + CNT_W'(1);
      end else begin
        cnt_r[g] <= cnt_r[g];
      end
    end

    assign pkt_cnt[g*CNT_W +: CNT_W] = cnt_r[g];
  end

endmodule : demux_1to4_stream

// File: tb/tb_demux_1to4_stream.sv
// Directed bench for demux_1to4_stream: a vector table for single beats and route lock,
// plus hand-written sequences for backpressure, load/drain overlap, reset and counter wrap.
module tb_demux_1to4_stream;

  localparam int DW = 8;
  localparam int CW = 2;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            in_last;
  logic [1:0]      sel;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic [4*DW-1:0] out_data;
  logic [3:0]      out_last;
  logic [4*CW-1:0] pkt_cnt;
  logic            busy;

  int checks;
  int errors;

  demux_1to4_stream #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .pkt_cnt   (pkt_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          vld;
    logic [7:0]    dat;
    logic          lst;
    logic [1:0]    sl;
    logic [3:0]    rdy;
    logic          exp_rdy;
    logic [3:0]    exp_ov;
    logic [1:0]    exp_lane;
    logic [7:0]    exp_dat;
    logic          exp_last;
    logic          exp_busy;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l,
                       input logic [1:0] s, input logic [3:0] r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    sel       = s;
    out_ready = r;
  endtask

  function automatic logic [7:0] lane_dat(input int ln);
    return out_data[ln*DW +: DW];
  endfunction

  function automatic logic [CW-1:0] lane_cnt(input int ln);
    return pkt_cnt[ln*CW +: CW];
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 2'b00, 4'b1111);

    //                vld   dat    lst   sel    rdy      exp_rdy exp_ov   lane   exp_dat exp_last exp_busy
    vecs[0] = '{1'b1, 8'hA0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 2'd0, 8'hA0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 8'hA1, 1'b1, 2'd1, 4'b1111, 1'b1, 4'b0010, 2'd1, 8'hA1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'hA2, 1'b1, 2'd2, 4'b1111, 1'b1, 4'b0100, 2'd2, 8'hA2, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'hA3, 1'b1, 2'd3, 4'b1111, 1'b1, 4'b1000, 2'd3, 8'hA3, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'hB0, 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 2'd2, 8'hB0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 8'hB1, 1'b0, 2'd1, 4'b1111, 1'b1, 4'b0100, 2'd2, 8'hB1, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 8'hB2, 1'b0, 2'd1, 4'b1111, 1'b1, 4'b0100, 2'd2, 8'hB2, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 8'hB3, 1'b1, 2'd1, 4'b1111, 1'b1, 4'b0100, 2'd2, 8'hB3, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_pkt_cnt",   32'(pkt_cnt),   32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready",  32'(in_ready),  32'h1);

    // Single beats to each lane, then a 4-beat packet locked to lane 2
    for (int k = 0; k < 10; k++) begin
      drive(vecs[k].vld, vecs[k].dat, vecs[k].lst, vecs[k].sl, vecs[k].rdy);
      #1;
      chk($sformatf("v%0d_in_ready", k), 32'(in_ready), 32'(vecs[k].exp_rdy));
      step();
      chk($sformatf("v%0d_out_valid", k), 32'(out_valid), 32'(vecs[k].exp_ov));
      chk($sformatf("v%0d_busy", k), 32'(busy), 32'(vecs[k].exp_busy));
      if (vecs[k].exp_ov != 4'b0000) begin
        chk($sformatf("v%0d_data", k), 32'(lane_dat(int'(vecs[k].exp_lane))), 32'(vecs[k].exp_dat));
        chk($sformatf("v%0d_last", k), 32'(out_last[vecs[k].exp_lane]), 32'(vecs[k].exp_last));
      end
      if (k == 4) begin
        for (int ln = 0; ln < 4; ln++)
          chk($sformatf("single_cnt%0d", ln), 32'(lane_cnt(ln)), 32'h1);
      end
    end
    chk("lock_cnt2", 32'(lane_cnt(2)), 32'h2);
    chk("lock_cnt1", 32'(lane_cnt(1)), 32'h1);

    // Backpressure on lane 3
    drive(1'b1, 8'hC0, 1'b1, 2'd3, 4'b0111);
    #1;
    chk("bp_rdy0", 32'(in_ready), 32'h1);
    step();
    drive(1'b1, 8'hC1, 1'b1, 2'd3, 4'b0111);
    #1;
    chk("bp_rdy1", 32'(in_ready), 32'h0);
    chk("bp_hold_a", 32'(lane_dat(3)), 32'hC0);
    step();
    chk("bp_valid_b", 32'(out_valid[3]), 32'h1);
    chk("bp_hold_b", 32'(lane_dat(3)), 32'hC0);
    step();
    chk("bp_hold_c", 32'(lane_dat(3)), 32'hC0);
    out_ready = 4'b1111;
    #1;
    chk("bp_rdy2", 32'(in_ready), 32'h1);
    step();
    chk("bp_valid_d", 32'(out_valid[3]), 32'h1);
    chk("bp_second", 32'(lane_dat(3)), 32'hC1);
    drive(1'b0, 8'h00, 1'b0, 2'd0, 4'b1111);
    step();
    chk("bp_drained", 32'(out_valid), 32'h0);
    chk("bp_cnt3", 32'(lane_cnt(3)), 32'h3);

    // Simultaneous load and drain on lane 0
    drive(1'b1, 8'hD0, 1'b1, 2'd0, 4'b1111);
    step();
    chk("ld_first", 32'(lane_dat(0)), 32'hD0);
    drive(1'b1, 8'hD1, 1'b1, 2'd0, 4'b1111);
    #1;
    chk("ld_rdy", 32'(in_ready), 32'h1);
    step();
    chk("ld_valid", 32'(out_valid[0]), 32'h1);
    chk("ld_second", 32'(lane_dat(0)), 32'hD1);
    drive(1'b0, 8'h00, 1'b0, 2'd0, 4'b1111);
    step();
    chk("ld_cnt0", 32'(lane_cnt(0)), 32'h3);
    chk("ld_cnt_all", 32'(pkt_cnt), 32'({2'd3, 2'd2, 2'd1, 2'd3}));

    // Reset mid-packet with a full, stalled slot
    drive(1'b1, 8'hE0, 1'b0, 2'd2, 4'b1011);
    step();
    chk("mp_busy", 32'(busy), 32'h1);
    chk("mp_valid", 32'(out_valid), 32'h4);
    drive(1'b0, 8'h00, 1'b0, 2'd2, 4'b1111);
    rst_n = 1'b0;
    #1;
    chk("mp_rst_valid", 32'(out_valid), 32'h0);
    chk("mp_rst_cnt",   32'(pkt_cnt),   32'h0);
    chk("mp_rst_busy",  32'(busy),      32'h0);
    chk("mp_rst_rdy",   32'(in_ready),  32'h0);
    step();
    rst_n = 1'b1;
    #1;
    chk("mp_rel_rdy",  32'(in_ready), 32'h1);
    chk("mp_rel_busy", 32'(busy),     32'h0);

    // Counter wrap: five packets to lane 1 with a 2-bit counter
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'(8'h60 + k), 1'b1, 2'd1, 4'b1111);
      step();
      chk($sformatf("wrap_data%0d", k), 32'(lane_dat(1)), 32'(8'h60 + k));
    end
    drive(1'b0, 8'h00, 1'b0, 2'd0, 4'b1111);
    step();
    chk("wrap_cnt1", 32'(lane_cnt(1)), 32'h1);
    chk("wrap_valid", 32'(out_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_demux_1to4_stream
